// File: rtl/branch_predictor_bht_if.sv
// Bus between the pipeline (IF/EX stages) and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_bht_if;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    modport master (
        output PCF, PCE, BranchTypeE, BranchE, BrTargetE,
        output PredTakenE, PredTargetE, StallE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

    modport slave (
        input  PCF, PCE, BranchTypeE, BranchE, BrTargetE,
        input  PredTakenE, PredTargetE, StallE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup,
// combinational EX mispredict/redirect, trained from the EX branch outcome.
// Ports: clk, rst (async active-high), bp (branch_predictor_bht_if.slave).
// Optional macro BP_PERF_CNT_EN adds BrCntOut/MissCntOut counters.
`ifndef NOBRANCH
`define NOBRANCH 3'b000
`endif

module branch_predictor_bht #(
    parameter int ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_bht_if.slave bp
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]           BrCntOut,
    output logic [31:0]           MissCntOut
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit, is_br, train;
    logic [1:0]       ctr_e, ctr_d;
    logic [31:0]      pcf_plus4, pce_plus4;
    logic             mis;
    logic [31:0]      redir;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{bp.PCF[1:0], bp.PCE[1:0]};

    // IF lookup
    assign f_idx     = bp.PCF[IDX_W+1:2];
    assign f_tag     = bp.PCF[31:IDX_W+2];
    assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pcf_plus4 = bp.PCF + 32'd4;

    assign bp.PredTakenF  = f_hit & ctr_q[f_idx][1];
    assign bp.PredTargetF = bp.PredTakenF ? target_q[f_idx] : pcf_plus4;

    // EX lookup for training
    assign e_idx     = bp.PCE[IDX_W+1:2];
    assign e_tag     = bp.PCE[31:IDX_W+2];
    assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign is_br     = (bp.BranchTypeE != `NOBRANCH);
    assign train     = !bp.StallE;
    assign pce_plus4 = bp.PCE + 32'd4;
    assign ctr_e     = ctr_q[e_idx];

    always_comb begin
        ctr_d = ctr_e;
        if (bp.BranchE) begin
            if (ctr_e != 2'b11) ctr_d = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_d = ctr_e - 2'd1;
        end
    end

    always_comb begin
        mis   = 1'b0;
        redir = pce_plus4;
        if (is_br) begin
            if (bp.BranchE &&
                (!bp.PredTakenE || (bp.PredTargetE != bp.BrTargetE))) begin
                mis   = 1'b1;
                redir = bp.BrTargetE;
            end else if (!bp.BranchE && bp.PredTakenE) begin
                mis   = 1'b1;
            end
        end else if (bp.PredTakenE) begin
            // predicted-taken slot turned out not to be a branch (alias)
            mis = 1'b1;
        end
    end

    assign bp.MispredictE = mis;
    assign bp.RedirectPCE = redir;

    // valid/ctr carry reset state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (train) begin
            if (is_br && e_hit) begin
                ctr_q[e_idx] <= ctr_d;
            end else if (is_br && bp.BranchE) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= 2'b10;
            end else if (!is_br && e_hit) begin
                valid_q[e_idx] <= 1'b0;
            end
        end
    end

    // tag/target are don't-care while invalid, so they need no reset
    always_ff @(posedge clk) begin
        if (train && is_br && bp.BranchE) begin
            target_q[e_idx] <= bp.BrTargetE;
            if (!e_hit) tag_q[e_idx] <= e_tag;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (train) begin
            if (is_br) br_cnt_q   <= br_cnt_q + 32'd1;
            if (mis)   miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign BrCntOut   = br_cnt_q;
    assign MissCntOut = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with an expectation queue.
// Expectations are queued when stimulus is applied and compared when outputs settle.
`ifndef NOBRANCH
`define NOBRANCH 3'b000
`endif

module tb_branch_predictor_bht;
    localparam logic [2:0] BEQ = 3'b001;
    localparam logic [2:0] NB  = `NOBRANCH;

    typedef enum int { K_PTF, K_PTGT, K_MIS, K_RED, K_BRC, K_MSC } kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    branch_predictor_bht_if bus ();

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt, miss_cnt;
`endif

    branch_predictor_bht #(.ENTRIES(64)) dut (
        .clk(clk),
        .rst(rst),
        .bp (bus)
`ifdef BP_PERF_CNT_EN
        ,
        .BrCntOut  (br_cnt),
        .MissCntOut(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [31:0] pce, input logic [2:0] bt,
                      input logic br, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt,
                      input logic stall);
        bus.PCE         = pce;
        bus.BranchTypeE = bt;
        bus.BranchE     = br;
        bus.BrTargetE   = tgt;
        bus.PredTakenE  = ptk;
        bus.PredTargetE = ptgt;
        bus.StallE      = stall;
    endtask

    task automatic ex_idle();
        ex(32'h0000_1000, NB, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push(input string n, input kind_e k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic exp_f(input string n, input logic tk,
                         input logic [31:0] tgt);
        push({n, "_taken"}, K_PTF, {31'd0, tk});
        push({n, "_tgt"}, K_PTGT, tgt);
    endtask

    task automatic exp_e(input string n, input logic m,
                         input logic [31:0] rp);
        push({n, "_mis"}, K_MIS, {31'd0, m});
        push({n, "_redir"}, K_RED, rp);
    endtask

    task automatic compare();
        exp_t        e;
        logic [31:0] obs;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = 32'hDEAD_BEEF;
            case (e.kind)
                K_PTF:  obs = {31'd0, bus.PredTakenF};
                K_PTGT: obs = bus.PredTargetF;
                K_MIS:  obs = {31'd0, bus.MispredictE};
                K_RED:  obs = bus.RedirectPCE;
`ifdef BP_PERF_CNT_EN
                K_BRC:  obs = br_cnt;
                K_MSC:  obs = miss_cnt;
`endif
                default: obs = 32'hDEAD_BEEF;
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    initial begin
        bus.PCF = 32'h0000_0040;
        ex_idle();

        // during reset
        exp_f("rst_lookup", 1'b0, 32'h44);
        compare();
        tick();
        rst = 1'b0;

        // first taken branch misses and allocates (ctr=10)
        ex(32'h40, BEQ, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
        exp_f("cold_lookup", 1'b0, 32'h44);
        exp_e("cold_mis", 1'b1, 32'h20);
        compare();
        tick();

        // now predicted taken; correct predictions push ctr to 11
        ex(32'h40, BEQ, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
        exp_f("alloc_hit", 1'b1, 32'h20);
        exp_e("ok_taken1", 1'b0, 32'h44);
        compare();
        tick();
        compare();
        tick();

        // not-taken while predicted taken: 11 -> 10
        ex(32'h40, BEQ, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
        exp_e("nt_mis", 1'b1, 32'h44);
        compare();
        tick();
        exp_f("ctr10_taken", 1'b1, 32'h20);
        compare();

        // 10 -> 01 -> 00 -> 00
        tick();
        exp_f("ctr01", 1'b0, 32'h44);
        ex(32'h40, BEQ, 1'b0, 32'h20, 1'b0, 32'h44, 1'b0);
        exp_e("nt_ok", 1'b0, 32'h44);
        compare();
        tick();
        tick();
        ex(32'h40, BEQ, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
        compare();
        tick();
        exp_f("sat_floor", 1'b0, 32'h44);
        compare();
        tick();
        exp_f("ctr10_again", 1'b1, 32'h20);

        // taken, but target changed
        ex(32'h40, BEQ, 1'b1, 32'h28, 1'b1, 32'h20, 1'b0);
        exp_e("tgt_mis", 1'b1, 32'h28);
        compare();
        tick();
        exp_f("tgt_update", 1'b1, 32'h28);

        // non-branch alias that was predicted taken: redirect + invalidate
        ex(32'h40, NB, 1'b0, 32'h0, 1'b1, 32'h28, 1'b0);
        exp_e("nb_alias", 1'b1, 32'h44);
        compare();
        tick();
        ex_idle();
        exp_f("nb_invalid", 1'b0, 32'h44);
        compare();

        // same index, different tag
        ex(32'h40, BEQ, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
        tick();
        exp_f("realloc", 1'b1, 32'h20);
        ex(32'h140, BEQ, 1'b1, 32'h300, 1'b0, 32'h144, 1'b0);
        exp_e("alias_mis", 1'b1, 32'h300);
        compare();
        tick();
        ex_idle();
        exp_f("alias_evict", 1'b0, 32'h44);
        compare();
        bus.PCF = 32'h140;
        exp_f("alias_new", 1'b1, 32'h300);
        compare();

        // stalled branch held 3 cycles
        bus.PCF = 32'h80;
        ex(32'h80, BEQ, 1'b1, 32'h500, 1'b0, 32'h84, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_f("stall_lookup", 1'b0, 32'h84);
            exp_e("stall_mis", 1'b1, 32'h500);
            compare();
            tick();
        end
        bus.StallE = 1'b0;
        tick();
        exp_f("stall_release", 1'b1, 32'h500);
        ex(32'h80, BEQ, 1'b0, 32'h500, 1'b1, 32'h500, 1'b0);
        compare();
        tick();
        ex_idle();
        exp_f("stall_single", 1'b0, 32'h84);
        compare();

        // PC+4 wrap and flushed slot
        bus.PCF = 32'hFFFF_FFFC;
        ex(32'hFFFF_FFFC, NB, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        exp_f("wrap_f", 1'b0, 32'h0);
        exp_e("wrap_e", 1'b1, 32'h0);
        compare();
        ex(32'h200, NB, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exp_e("flushed", 1'b0, 32'h204);
        compare();

        // reset mid-training
        bus.PCF = 32'hC0;
        ex(32'hC0, BEQ, 1'b1, 32'h600, 1'b0, 32'hC4, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ex_idle();
        exp_f("rst_noalloc", 1'b0, 32'hC4);
        compare();
        bus.PCF = 32'h140;
        exp_f("rst_clear", 1'b0, 32'h144);
`ifdef BP_PERF_CNT_EN
        push("br_cnt_rst", K_BRC, 32'h0);
        push("miss_cnt_rst", K_MSC, 32'h0);
`endif
        compare();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
